// File: rtl/torrence_types.sv
// Shared L1 cache types: access sizes, data-array FSM states and the load
// extension helper used to shape read responses.
package torrence_types;

  localparam int BYTE_BITS = 8;
  localparam int HALF_BITS = 16;
  localparam int WORD_BITS = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memory_operation_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    EVICT = 2'd2
  } cache_data_state_e;

  // HALF selects by byte_select[1] only; unknown sizes return X on purpose.
  function automatic logic [WORD_BITS-1:0] load_extend(
    input memory_operation_size_e size,
    input logic                   is_unsigned,
    input logic [1:0]             byte_select,
    input logic [WORD_BITS-1:0]   word
  );
    logic [BYTE_BITS-1:0] b;
    logic [HALF_BITS-1:0] h;
    b = word[byte_select*BYTE_BITS +: BYTE_BITS];
    h = word[byte_select[1]*HALF_BITS +: HALF_BITS];
    case (size)
      BYTE:    return {{(WORD_BITS-BYTE_BITS){b[BYTE_BITS-1] & ~is_unsigned}}, b};
      HALF:    return {{(WORD_BITS-HALF_BITS){h[HALF_BITS-1] & ~is_unsigned}}, h};
      WORD:    return word;
      default: return 'x;
    endcase
  endfunction

endpackage

// File: rtl/cache_way_bank.sv
// One way of the cache data array: byte-lane write enables and a
// combinational word read. Each lane may carry extra bits (e.g. parity).
module cache_way_bank #(
  parameter int DEPTH  = 32,
  parameter int LANE_W = 8,
  parameter int LANES  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    wen,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [LANES-1:0]        wbe,
  input  logic [LANES*LANE_W-1:0] wdata,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [LANES*LANE_W-1:0] rdata
);

  logic [LANES*LANE_W-1:0] mem [DEPTH];

  // NOTE: storage array has no reset; contents survive rst and power up undefined.
  always_ff @(posedge clk) begin
    if (wen) begin
      for (int i = 0; i < LANES; i++) begin
        if (wbe[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cache_data_array.sv
// Set-associative L1 data store with registered loads, burst fill and burst
// evict. Define CACHE_DATA_PARITY_EN for per-byte even parity and parity_err.
module cache_data_array
  import torrence_types::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_SETS       = 4,
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 8,
  localparam int SET_SIZE         = $clog2(NUM_SETS),
  localparam int WORD_SELECT_SIZE = $clog2(WORDS_PER_LINE),
  localparam int WAY_SIZE         = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [SET_SIZE-1:0]         req_set,
  input  logic [WAY_SIZE-1:0]         req_way,
  input  memory_operation_size_e      req_size,
  input  logic                        req_unsigned,
  input  logic [WORD_SELECT_SIZE-1:0] req_word,
  input  logic [1:0]                  req_byte,
  input  logic [XLEN-1:0]             req_wdata,
  output logic                        rsp_valid,
  output logic [XLEN-1:0]             rsp_rdata,
  input  logic                        fill_start,
  input  logic [SET_SIZE-1:0]         fill_set,
  input  logic [WAY_SIZE-1:0]         fill_way,
  input  logic                        fill_valid,
  output logic                        fill_ready,
  input  logic [XLEN-1:0]             fill_data,
  output logic                        fill_done,
  input  logic                        evict_start,
  input  logic [SET_SIZE-1:0]         evict_set,
  input  logic [WAY_SIZE-1:0]         evict_way,
  output logic                        evict_valid,
  input  logic                        evict_ready,
  output logic [XLEN-1:0]             evict_data,
  output logic                        evict_last,
  output logic                        busy
`ifdef CACHE_DATA_PARITY_EN
  ,
  output logic                        parity_err
`endif
);

  localparam int LANES = XLEN / BYTE_BITS;
  localparam int DEPTH = NUM_SETS * WORDS_PER_LINE;
`ifdef CACHE_DATA_PARITY_EN
  localparam int LANE_W = BYTE_BITS + 1;
`else
  localparam int LANE_W = BYTE_BITS;
`endif
  localparam logic [WORD_SELECT_SIZE-1:0] LAST_WORD = WORD_SELECT_SIZE'(WORDS_PER_LINE - 1);

  cache_data_state_e           state;
  logic [WORD_SELECT_SIZE-1:0] count;
  logic [SET_SIZE-1:0]         op_set;
  logic [WAY_SIZE-1:0]         op_way;
  logic                        accept;

  logic                        wr_en;
  logic [SET_SIZE-1:0]         wr_set;
  logic [WAY_SIZE-1:0]         wr_way;
  logic [WORD_SELECT_SIZE-1:0] wr_word;
  logic [LANES-1:0]            wr_be;
  logic [XLEN-1:0]             wr_data;
  logic [LANES*LANE_W-1:0]     wr_lanes;

  logic [SET_SIZE-1:0]         rd_set;
  logic [WAY_SIZE-1:0]         rd_way;
  logic [WORD_SELECT_SIZE-1:0] rd_word;
  logic [LANES*LANE_W-1:0]     way_rdata [NUM_WAYS];
  logic [LANES*LANE_W-1:0]     rd_lanes;
  logic [XLEN-1:0]             rd_data;
`ifdef CACHE_DATA_PARITY_EN
  logic                        rd_parity_bad;
`endif

  assign req_ready = (state == IDLE) && !evict_start && !fill_start;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);

  // Single write port: refill beats own it in FILL, CPU stores otherwise.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    wr_be   = '0;
    wr_data = req_wdata;
    case (req_size)
      BYTE:    begin wr_be = 4'b0001 << req_byte;          wr_data = {4{req_wdata[7:0]}};  end
      HALF:    begin wr_be = 4'b0011 << {req_byte[1], 1'b0}; wr_data = {2{req_wdata[15:0]}}; end
      WORD:    wr_be = 4'b1111;
      default: wr_be = '0;
    endcase
    wr_en   = accept && req_write;
    wr_set  = req_set;
    wr_way  = req_way;
    wr_word = req_word;
    if (state == FILL) begin
      wr_en   = fill_valid;
      wr_set  = op_set;
      wr_way  = op_way;
      wr_word = count;
      wr_be   = 4'b1111;
      wr_data = fill_data;
    end
    for (int i = 0; i < LANES; i++) begin
`ifdef CACHE_DATA_PARITY_EN
      wr_lanes[i*LANE_W +: LANE_W] = {^wr_data[i*BYTE_BITS +: BYTE_BITS], wr_data[i*BYTE_BITS +: BYTE_BITS]};
`else
      wr_lanes[i*LANE_W +: LANE_W] = wr_data[i*BYTE_BITS +: BYTE_BITS];
`endif
    end
  end

  // Evict reads one word ahead so the next beat is ready at the handshake edge.
  always_comb begin
    rd_set  = req_set;
    rd_way  = req_way;
    rd_word = req_word;
    if (state == EVICT) begin
      rd_set  = op_set;
      rd_way  = op_way;
      rd_word = count + 1'b1;
    end else if (evict_start) begin
      rd_set  = evict_set;
      rd_way  = evict_way;
      rd_word = '0;
    end
    rd_lanes = way_rdata[rd_way];
`ifdef CACHE_DATA_PARITY_EN
    rd_parity_bad = 1'b0;
`endif
    for (int i = 0; i < LANES; i++) begin
      rd_data[i*BYTE_BITS +: BYTE_BITS] = rd_lanes[i*LANE_W +: BYTE_BITS];
`ifdef CACHE_DATA_PARITY_EN
      rd_parity_bad = rd_parity_bad | (^rd_lanes[i*LANE_W +: LANE_W]);
`endif
    end
  end

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    cache_way_bank #(
      .DEPTH (DEPTH),
      .LANE_W(LANE_W),
      .LANES (LANES)
    ) u_bank (
      .clk  (clk),
      .wen  (wr_en && (wr_way == WAY_SIZE'(g))),
      .waddr({wr_set, wr_word}),
      .wbe  (wr_be),
      .wdata(wr_lanes),
      .raddr({rd_set, rd_word}),
      .rdata(way_rdata[g])
    );
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      op_set      <= '0;
      op_way      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      fill_ready  <= 1'b0;
      fill_done   <= 1'b0;
      evict_valid <= 1'b0;
      evict_data  <= '0;
      evict_last  <= 1'b0;
`ifdef CACHE_DATA_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      fill_done <= 1'b0;
`ifdef CACHE_DATA_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (evict_start) begin
            state       <= EVICT;
            op_set      <= evict_set;
            op_way      <= evict_way;
            count       <= '0;
            evict_valid <= 1'b1;
            evict_data  <= rd_data;
            evict_last  <= 1'b0;
`ifdef CACHE_DATA_PARITY_EN
            parity_err  <= rd_parity_bad;
`endif
          end else if (fill_start) begin
            state      <= FILL;
            op_set     <= fill_set;
            op_way     <= fill_way;
            count      <= '0;
            fill_ready <= 1'b1;
          end else if (accept && !req_write) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= load_extend(req_size, req_unsigned, req_byte, rd_data);
`ifdef CACHE_DATA_PARITY_EN
            parity_err <= rd_parity_bad;
`endif
          end
        end
        FILL: begin
          if (fill_valid) begin
            count <= count + 1'b1;
            if (count == LAST_WORD) begin
              state      <= IDLE;
              fill_ready <= 1'b0;
              fill_done  <= 1'b1;
            end
          end
        end
        EVICT: begin
          if (evict_ready) begin
            if (count == LAST_WORD) begin
              state       <= IDLE;
              count       <= '0;
              evict_valid <= 1'b0;
              evict_last  <= 1'b0;
            end else begin
              count      <= count + 1'b1;
              evict_data <= rd_data;
              evict_last <= (count == LAST_WORD - 1'b1);
`ifdef CACHE_DATA_PARITY_EN
              parity_err <= rd_parity_bad;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_data_array.sv
// Directed bench for cache_data_array: loads and evict beats are checked
// against scoreboard queues filled when the stimulus is driven.
module tb_cache_data_array;
  import torrence_types::*;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]             req_set;
  logic                   req_way;
  memory_operation_size_e req_size;
  logic [2:0]             req_word;
  logic [1:0]             req_byte;
  logic [31:0]            req_wdata;
  logic                   rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   fill_start, fill_way, fill_valid, fill_ready, fill_done;
  logic [1:0]             fill_set;
  logic [31:0]            fill_data;
  logic                   evict_start, evict_way, evict_valid, evict_ready, evict_last;
  logic [1:0]             evict_set;
  logic [31:0]            evict_data;
  logic                   busy;
`ifdef CACHE_DATA_PARITY_EN
  logic                   parity_err;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rsp_q[$];
  logic [32:0] ev_q[$];
  logic [32:0] ev_exp;
  logic        ev_prev_stall = 1'b0;
  logic        ev_prev_adv   = 1'b0;
  logic [31:0] ev_prev_data;
  logic        ev_prev_last;

  cache_data_array dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_set     (req_set),
    .req_way     (req_way),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_word    (req_word),
    .req_byte    (req_byte),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .fill_start  (fill_start),
    .fill_set    (fill_set),
    .fill_way    (fill_way),
    .fill_valid  (fill_valid),
    .fill_ready  (fill_ready),
    .fill_data   (fill_data),
    .fill_done   (fill_done),
    .evict_start (evict_start),
    .evict_set   (evict_set),
    .evict_way   (evict_way),
    .evict_valid (evict_valid),
    .evict_ready (evict_ready),
    .evict_data  (evict_data),
    .evict_last  (evict_last),
    .busy        (busy)
`ifdef CACHE_DATA_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [1:0] set, input logic way, input memory_operation_size_e sz,
                       input logic [2:0] word, input logic [1:0] bsel, input logic [31:0] d);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_set = set; req_way = way;
    req_size = sz; req_word = word; req_byte = bsel; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic load(input logic [1:0] set, input logic way, input memory_operation_size_e sz,
                      input logic [2:0] word, input logic [1:0] bsel, input logic uns,
                      input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_set = set; req_way = way;
    req_size = sz; req_word = word; req_byte = bsel; req_unsigned = uns;
    rsp_q.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      if (rsp_q.size() == 0) check("rsp_spurious", 32'(rsp_valid), 32'd0);
      else check("rsp_rdata", rsp_rdata, rsp_q.pop_front());
    end
  end

  // Evict scoreboard: ordering, last flag, stall stability, no bubbles.
  always @(negedge clk) begin
    if (!reset_n) begin
      ev_prev_stall = 1'b0;
      ev_prev_adv   = 1'b0;
    end else begin
      if (evict_valid) begin
        if (ev_prev_stall) begin
          check("evict_hold_data", evict_data, ev_prev_data);
          check("evict_hold_last", 32'(evict_last), 32'(ev_prev_last));
        end
        if (evict_ready) begin
          if (ev_q.size() == 0) check("evict_spurious", 32'(evict_valid), 32'd0);
          else begin
            ev_exp = ev_q.pop_front();
            check("evict_data", evict_data, ev_exp[31:0]);
            check("evict_last", 32'(evict_last), 32'(ev_exp[32]));
          end
        end
      end else if (ev_prev_adv) begin
        check("evict_bubble", 32'(evict_valid), 32'd1);
      end
      ev_prev_stall = evict_valid & ~evict_ready;
      ev_prev_adv   = evict_valid & evict_ready & ~evict_last;
      ev_prev_data  = evict_data;
      ev_prev_last  = evict_last;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    req_valid = 0; req_write = 0; req_set = 0; req_way = 0; req_size = WORD;
    req_unsigned = 0; req_word = 0; req_byte = 0; req_wdata = 0;
    fill_start = 0; fill_set = 0; fill_way = 0; fill_valid = 0; fill_data = 0;
    evict_start = 0; evict_set = 0; evict_way = 0; evict_ready = 0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    check("rst_rsp_rdata",   rsp_rdata,        32'd0);
    check("rst_fill_ready",  32'(fill_ready),  32'd0);
    check("rst_fill_done",   32'(fill_done),   32'd0);
    check("rst_evict_valid", 32'(evict_valid), 32'd0);
    check("rst_evict_data",  evict_data,       32'd0);
    check("rst_evict_last",  32'(evict_last),  32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_req_ready",   32'(req_ready),   32'd1);
    @(posedge clk); #1 reset_n = 1'b1;

    // Stores and extended loads
    store(2'd1, 1'b0, WORD, 3'd3, 2'd0, 32'h55667788);
    store(2'd1, 1'b1, WORD, 3'd3, 2'd0, 32'hDEADBEEF);
    load(2'd1, 1'b1, BYTE, 3'd3, 2'd2, 1'b0, 32'hFFFFFFAD, "ld_byte_s");
    load(2'd1, 1'b1, BYTE, 3'd3, 2'd2, 1'b1, 32'h000000AD, "ld_byte_u");
    store(2'd1, 1'b1, HALF, 3'd3, 2'd2, 32'hAAAA1234);
    load(2'd1, 1'b1, WORD, 3'd3, 2'd0, 1'b0, 32'h1234BEEF, "ld_word");
    load(2'd1, 1'b1, HALF, 3'd3, 2'd3, 1'b0, 32'h00001234, "ld_half_hi");
    load(2'd1, 1'b1, HALF, 3'd3, 2'd0, 1'b0, 32'hFFFFBEEF, "ld_half_lo_s");
    load(2'd1, 1'b0, WORD, 3'd3, 2'd1, 1'b0, 32'h55667788, "ld_way0");

    // Fill set2 way0 with gaps on the 4th and 6th cycles
    @(posedge clk); #1 fill_start = 1'b1; fill_set = 2'd2; fill_way = 1'b0;
    @(posedge clk); #1 fill_start = 1'b0;
    @(negedge clk);
    check("fill_busy",  32'(busy),       32'd1);
    check("fill_ready", 32'(fill_ready), 32'd1);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      fill_valid = !(c == 3 || c == 5);
      fill_data  = 32'h100 + k;
      if (fill_valid) k++;
      if (c == 9) begin
        @(negedge clk);
        check("fill_done_early", 32'(fill_done), 32'd0);
      end
    end
    @(posedge clk); #1 fill_valid = 1'b0;
    @(negedge clk);
    check("fill_done",        32'(fill_done),  32'd1);
    check("fill_end_busy",    32'(busy),       32'd0);
    check("fill_end_ready",   32'(fill_ready), 32'd0);
    @(negedge clk);
    check("fill_done_pulse",  32'(fill_done),  32'd0);
    for (int i = 0; i < 8; i++)
      load(2'd2, 1'b0, WORD, 3'(i), 2'd0, 1'b1, 32'h100 + i, "ld_fill");

    // Evict set2 way0 with evict_ready toggling 1010...
    for (int i = 0; i < 8; i++) ev_q.push_back({i == 7, 32'h100 + i});
    @(posedge clk); #1 evict_start = 1'b1; evict_set = 2'd2; evict_way = 1'b0; evict_ready = 1'b0;
    @(posedge clk); #1 evict_start = 1'b0; evict_ready = 1'b1;
    @(negedge clk);
    check("evict_rise", 32'(evict_valid), 32'd1);
    for (int c = 1; c < 60; c++) begin
      if (ev_q.size() == 0 && !evict_valid) break;
      @(posedge clk); #1 evict_ready = (c % 2 == 0);
      @(negedge clk);
    end
    check("evict_queue_drained", 32'(ev_q.size()), 32'd0);
    check("evict_end_busy",      32'(busy),        32'd0);
    check("evict_end_last",      32'(evict_last),  32'd0);

    // Simultaneous evict_start, fill_start and req_valid: evict wins
    for (int i = 0; i < 8; i++) ev_q.push_back({i == 7, 32'h100 + i});
    @(posedge clk); #1;
    evict_start = 1'b1; evict_set = 2'd2; evict_way = 1'b0; evict_ready = 1'b1;
    fill_start = 1'b1; fill_set = 2'd0; fill_way = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_set = 2'd2; req_way = 1'b0; req_size = WORD; req_word = 3'd0;
    @(negedge clk);
    check("prio_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 evict_start = 1'b0; fill_start = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("prio_busy",        32'(busy),        32'd1);
    check("prio_evict_valid", 32'(evict_valid), 32'd1);
    check("prio_no_fill",     32'(fill_ready),  32'd0);
    for (int c = 0; c < 30; c++) begin
      if (ev_q.size() == 0 && !evict_valid) break;
      @(negedge clk);
    end
    check("prio_queue_drained", 32'(ev_q.size()), 32'd0);
    check("prio_end_busy",      32'(busy),        32'd0);
    check("prio_end_fill",      32'(fill_ready),  32'd0);
    evict_ready = 1'b0;

    // Reset in the middle of a fill
    @(posedge clk); #1 fill_start = 1'b1; fill_set = 2'd3; fill_way = 1'b1;
    @(posedge clk); #1 fill_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fill_valid = 1'b1; fill_data = 32'h200 + i;
      @(posedge clk); #1;
    end
    fill_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",        32'(busy),        32'd0);
    check("mid_rst_fill_ready",  32'(fill_ready),  32'd0);
    check("mid_rst_fill_done",   32'(fill_done),   32'd0);
    check("mid_rst_evict_valid", 32'(evict_valid), 32'd0);
    check("mid_rst_rsp_rdata",   rsp_rdata,        32'd0);
    check("mid_rst_req_ready",   32'(req_ready),   32'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++)
      load(2'd3, 1'b1, WORD, 3'(i), 2'd0, 1'b1, 32'h200 + i, "ld_after_rst");

    repeat (2) @(negedge clk);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_data_array.md
Name: cache_data_array

Overview:
Set-associative data store for the L1 caches, successor to the single-way line array. Adds ways, registered read responses with sign/zero extension, and a burst line-fill port for refills from the memory side. Also adds a burst line-evict port for dirty writebacks. Sits under the cache controller FSM, which owns tags/valid/dirty and issues requests, fills and evictions.

Parameters:
XLEN, 32, data word width in bits; must be 32 (4 bytes/word).
NUM_SETS, 4, sets per way; power of two >= 2.
NUM_WAYS, 2, associativity; power of two >= 1; way index width max(1,$clog2(NUM_WAYS)).
WORDS_PER_LINE, 8, words per line; power of two >= 2.
SET_SIZE, $clog2(NUM_SETS), set index width (derived, not overridden).
WORD_SELECT_SIZE, $clog2(WORDS_PER_LINE), word index width (derived).

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  CPU access request
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1=store, 0=load
req_set  in  SET_SIZE  set index
req_way  in  WAY_SIZE  way index (hit way from tag compare)
req_size  in  memory_operation_size_e  BYTE/HALF/WORD
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_word  in  WORD_SELECT_SIZE  word in line
req_byte  in  2  byte in word
req_wdata  in  XLEN  store data, low bits used for BYTE/HALF
rsp_valid  out  1  one-cycle pulse, load data valid
rsp_rdata  out  XLEN  extended load data
fill_start  in  1  begin refill of (fill_set, fill_way)
fill_set  in  SET_SIZE  refill target set, sampled with fill_start
fill_way  in  WAY_SIZE  refill target way, sampled with fill_start
fill_valid  in  1  refill beat valid
fill_ready  out  1  array accepting refill beats
fill_data  in  XLEN  refill word, word 0 first
fill_done  out  1  one-cycle pulse after final beat written
evict_start  in  1  begin readout of (evict_set, evict_way)
evict_set  in  SET_SIZE  sampled with evict_start
evict_way  in  WAY_SIZE  sampled with evict_start
evict_valid  out  1  evict beat valid
evict_ready  in  1  downstream accepts beat
evict_data  out  XLEN  evicted word, word 0 first
evict_last  out  1  marks final evict beat
busy  out  1  state != IDLE

Behaviour:
Reset: state=IDLE, beat counter=0, rsp_valid=0, rsp_rdata=0, fill_ready=0, fill_done=0, evict_valid=0, evict_data=0, evict_last=0, busy=0. Data storage is not reset; contents undefined after power-up and preserved across reset.
FSM states: IDLE, FILL, EVICT. Only IDLE accepts new work. Priority in IDLE: evict_start > fill_start > req_valid. req_ready = IDLE & !evict_start & !fill_start. Starts outside IDLE are ignored; controller must not issue them.
Load: accepted cycle N -> rsp_valid=1 and rsp_rdata at cycle N+1. BYTE selects byte req_byte; HALF selects half req_byte[1] (req_byte[0] ignored); WORD ignores req_byte. Extension is per req_unsigned.
Store: written at the accepting edge with byte enables as in the previous array: BYTE 1<<req_byte, HALF 2'b11<<(2*req_byte[1]), WORD 4'b1111. No response. A load the next cycle to the same address returns the new data.
Illegal req_size: no write; rsp_rdata is X.
FILL: counter=0 on entry. fill_ready=1 throughout FILL. Each fill_valid writes the full word[counter] of the latched set/way, then counter++. The beat at counter=WORDS_PER_LINE-1 wraps counter to 0 and moves to IDLE; fill_done pulses the following cycle. fill_valid gaps are allowed.
EVICT: evict_valid rises the cycle after evict_start with word 0. evict_data/evict_last are held stable while evict_valid & !evict_ready. On each handshake the next word is presented the next cycle with no bubble. After the last handshake: evict_valid=0, state IDLE.
Reset mid-FILL/EVICT: aborts to IDLE; words already filled remain written.

Optional Feature:
CACHE_DATA_PARITY_EN: defined adds one even-parity bit per stored byte, generated on store/fill. Adds output parity_err (1 bit), pulsed with rsp_valid or an evict beat when any read byte mismatches; data is still returned. Undefined: no parity storage, no parity_err port.

Decomposition:
Package torrence_types (existing): memory_operation_size_e. Add cache_data_state_e {IDLE, FILL, EVICT} and a load-extension function (size, unsigned, byte_select, word) -> XLEN. BYTE/HALF/WORD widths come from the existing macros.
Sub-module cache_way_bank: one way's storage with byte-enable write port and combinational word read, instantiated NUM_WAYS times by generate.

Test Plan:
Store WORD 0xDEADBEEF set1 way1 word3, then load BYTE byte2 signed -> rsp_valid next cycle, rsp_rdata=0xFFFFFFAD; unsigned -> 0x000000AD.
Store HALF 0x1234 at byte2, then load WORD -> 0x1234BEEF; way0 set1 word3 unchanged.
Fill set2 way0 with 0x100..0x107, fill_valid low on beats 3 and 5 -> fill_done one cycle after beat 7; loads return 0x100+i.
Evict set2 way0 with evict_ready toggling 1010… -> 8 beats 0x100..0x107 in order, data stable under stall, evict_last only on 0x107.
Assert evict_start, fill_start and req_valid in the same cycle -> EVICT entered, req_ready=0, fill ignored.
Assert reset_n low after fill beat 4 -> all outputs at reset values, IDLE; words 0-3 retain filled data.
